// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared constants for the immediate generator.
//   - imm_type_e : IMM_TYPE output encoding (NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6)
//   - Op*        : RV32/RV64 base major opcodes (INSTRUCTION[6:0])
package imm_gen_pkg;

    typedef enum logic [2:0] {
        ImmNone = 3'd0,
        ImmI    = 3'd1,
        ImmS    = 3'd2,
        ImmB    = 3'd3,
        ImmU    = 3'd4,
        ImmJ    = 3'd5,
        ImmZ    = 3'd6
    } imm_type_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpSystem = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// imm_decode: purely combinational immediate formatter.
//   instr_i    : 32-bit RV32/RV64 base instruction word
//   imm_o      : immediate, sign-extended from instr_i[31] to XLEN (Z zero-extended)
//   imm_type_o : format code (imm_gen_pkg::imm_type_e)
// Optional feature macro IMM_GEN_CSR_EN: decodes SYSTEM opcode as Z (funct3[2]=1,
// zimm in rs1 field) or I (funct3[2]=0). Without it SYSTEM decodes as NONE.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_type_e       imm_type_o
);

    logic [6:0]  opcode;
    logic [31:0] imm32;

    assign opcode = instr_i[6:0];

    always_comb begin
        imm32      = '0;
        imm_type_o = ImmNone;
        case (opcode)
            OpLoad, OpImm, OpJalr: begin
                imm32      = {{20{instr_i[31]}}, instr_i[31:20]};
                imm_type_o = ImmI;
            end
            OpStore: begin
                imm32      = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                imm_type_o = ImmS;
            end
            OpBranch: begin
                imm32      = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
                imm_type_o = ImmB;
            end
            OpLui, OpAuipc: begin
                imm32      = {instr_i[31:12], 12'b0};
                imm_type_o = ImmU;
            end
            OpJal: begin
                imm32      = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
                imm_type_o = ImmJ;
            end
`ifdef IMM_GEN_CSR_EN
            OpSystem: begin
                if (instr_i[14]) begin
                    // zimm lives in the rs1 field; bit 31 of imm32 stays 0 so the
                    // signed widening below zero-extends it.
                    imm32      = {27'b0, instr_i[19:15]};
                    imm_type_o = ImmZ;
                end else begin
                    imm32      = {{20{instr_i[31]}}, instr_i[31:20]};
                    imm_type_o = ImmI;
                end
            end
`endif
            default: begin
                imm32      = '0;
                imm_type_o = ImmNone;
            end
        endcase
    end

    // Every format is built as 32 bits then widened with bit 31 as sign.
    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: one-cycle-latency immediate generator with a two-entry
// (output register + skid register) valid/ready buffer.
//   CLK, RESET (async, active-high), FLUSH (sync discard of both entries)
//   IN_VALID / IN_READY / INSTRUCTION / IN_TAG   : upstream handshake
//   OUT_VALID / OUT_READY / IMMEDIATE / IMM_TYPE / OUT_TAG : downstream handshake
// Parameters: XLEN (32 or 64), TAG_W (sideband tag width).
// Optional feature macro IMM_GEN_CSR_EN (see imm_decode).
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      INSTRUCTION,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  IMMEDIATE,
    output logic [2:0]       IMM_TYPE,
    output logic [TAG_W-1:0] OUT_TAG
);

    logic [XLEN-1:0]  dec_imm;
    imm_type_e        dec_type;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    imm_type_e        out_type_q, out_type_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    imm_type_e        skid_type_q, skid_type_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

    logic             in_fire;
    logic             out_free;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i    (INSTRUCTION),
        .imm_o      (dec_imm),
        .imm_type_o (dec_type)
    );

    // IN_READY depends only on a flop, so no combinational path from OUT_READY.
    assign IN_READY = ~skid_valid_q;
    assign in_fire  = IN_VALID & ~skid_valid_q;
    // Output register can take a new entry this cycle (empty or draining).
    assign out_free = ~out_valid_q | OUT_READY;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_type_d   = out_type_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_type_d  = skid_type_q;
        skid_tag_d   = skid_tag_q;

        if (FLUSH) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // Older entry first; in_fire is 0 here because the skid is full.
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_type_d   = skid_type_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_type_d  = dec_type;
                out_tag_d   = IN_TAG;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            // Output stalled: park the new entry behind it.
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_type_d  = dec_type;
            skid_tag_d   = IN_TAG;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_type_q   <= ImmNone;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_type_q  <= ImmNone;
            skid_tag_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_type_q   <= out_type_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_type_q  <= skid_type_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign IMMEDIATE = out_imm_q;
    assign IMM_TYPE  = out_type_q;
    assign OUT_TAG   = out_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed self-checking bench. Two instances (XLEN=32 and
// XLEN=64) share all inputs; inputs change and outputs are sampled on the
// falling clock edge.
module tb_imm_gen_pipe;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] instruction;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32;
    logic [31:0] imm32;
    logic [2:0]  type32;
    logic [7:0]  tag32;

    logic        in_ready64, out_valid64;
    logic [63:0] imm64;
    logic [2:0]  type64;
    logic [7:0]  tag64;

    int checks = 0;
    int errors = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
        .CLK         (clk),
        .RESET       (reset),
        .FLUSH       (flush),
        .IN_VALID    (in_valid),
        .IN_READY    (in_ready32),
        .INSTRUCTION (instruction),
        .IN_TAG      (in_tag),
        .OUT_VALID   (out_valid32),
        .OUT_READY   (out_ready),
        .IMMEDIATE   (imm32),
        .IMM_TYPE    (type32),
        .OUT_TAG     (tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
        .CLK         (clk),
        .RESET       (reset),
        .FLUSH       (flush),
        .IN_VALID    (in_valid),
        .IN_READY    (in_ready64),
        .INSTRUCTION (instruction),
        .IN_TAG      (in_tag),
        .OUT_VALID   (out_valid64),
        .OUT_READY   (out_ready),
        .IMMEDIATE   (imm64),
        .IMM_TYPE    (type64),
        .OUT_TAG     (tag64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid32);
        end
        checks++;
        if (in_ready32 !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready32);
        end
        checks++;
        if (imm32 !== 32'h0 || imm64 !== 64'h0) begin
            errors++; $display("FAIL reset_imm: got %h / %h expected 0", imm32, imm64);
        end
        checks++;
        if (type32 !== 3'd0 || tag32 !== 8'h00) begin
            errors++; $display("FAIL reset_type_tag: got %0d/%h expected 0/00", type32, tag32);
        end
        reset = 1'b0;
    endtask

    // Back-to-back stream under OUT_READY=1: one result per cycle, one cycle latency.
    task automatic test_decode_stream();
        logic [31:0] vin  [9];
        logic [31:0] e32  [9];
        logic [63:0] e64  [9];
        logic [2:0]  etyp [9];
        vin[0] = 32'hFFF00093; e32[0] = 32'hFFFFFFFF; e64[0] = 64'hFFFFFFFF_FFFFFFFF; etyp[0] = 3'd1;
        vin[1] = 32'hFE000EE3; e32[1] = 32'hFFFFFFFC; e64[1] = 64'hFFFFFFFF_FFFFFFFC; etyp[1] = 3'd3;
        vin[2] = 32'h800000B7; e32[2] = 32'h80000000; e64[2] = 64'hFFFFFFFF_80000000; etyp[2] = 3'd4;
        vin[3] = 32'h00112623; e32[3] = 32'h0000000C; e64[3] = 64'h0000000C;          etyp[3] = 3'd2;
        vin[4] = 32'hFFDFF06F; e32[4] = 32'hFFFFFFFC; e64[4] = 64'hFFFFFFFF_FFFFFFFC; etyp[4] = 3'd5;
        vin[5] = 32'h12345017; e32[5] = 32'h12345000; e64[5] = 64'h12345000;          etyp[5] = 3'd4;
        vin[6] = 32'h002081B3; e32[6] = 32'h0;        e64[6] = 64'h0;                 etyp[6] = 3'd0;
`ifdef IMM_GEN_CSR_EN
        vin[7] = 32'h300FD073; e32[7] = 32'h0000001F; e64[7] = 64'h1F;                etyp[7] = 3'd6;
        vin[8] = 32'h30029073; e32[8] = 32'h00000300; e64[8] = 64'h300;               etyp[8] = 3'd1;
`else
        vin[7] = 32'h300FD073; e32[7] = 32'h0;        e64[7] = 64'h0;                 etyp[7] = 3'd0;
        vin[8] = 32'h30029073; e32[8] = 32'h0;        e64[8] = 64'h0;                 etyp[8] = 3'd0;
`endif
        out_ready = 1'b1;
        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (out_valid32 !== 1'b1 || out_valid64 !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_valid[%0d]: got %b/%b expected 1/1",
                             i - 1, out_valid32, out_valid64);
                end
                checks++;
                if (imm32 !== e32[i-1]) begin
                    errors++;
                    $display("FAIL stream_imm32[%0d]: got %h expected %h", i - 1, imm32, e32[i-1]);
                end
                checks++;
                if (imm64 !== e64[i-1]) begin
                    errors++;
                    $display("FAIL stream_imm64[%0d]: got %h expected %h", i - 1, imm64, e64[i-1]);
                end
                checks++;
                if (type32 !== etyp[i-1] || type64 !== etyp[i-1]) begin
                    errors++;
                    $display("FAIL stream_type[%0d]: got %0d/%0d expected %0d",
                             i - 1, type32, type64, etyp[i-1]);
                end
                checks++;
                if (tag32 !== 8'h40 + 8'(i - 1)) begin
                    errors++;
                    $display("FAIL stream_tag[%0d]: got %h expected %h",
                             i - 1, tag32, 8'h40 + 8'(i - 1));
                end
            end
            checks++;
            if (in_ready32 !== 1'b1) begin
                errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready32);
            end
            if (i < 9) begin
                in_valid    = 1'b1;
                instruction = vin[i];
                in_tag      = 8'h40 + 8'(i);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b0) begin
            errors++; $display("FAIL stream_drain: got %b expected 0", out_valid32);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; instruction = 32'hFFF00093; in_tag = 8'd1;
        @(negedge clk);
        checks++;
        if (in_ready32 !== 1'b1) begin
            errors++; $display("FAIL bp_ready_after1: got %b expected 1", in_ready32);
        end
        instruction = 32'h800000B7; in_tag = 8'd2;
        @(negedge clk);
        checks++;
        if (in_ready32 !== 1'b0) begin
            errors++; $display("FAIL bp_ready_after2: got %b expected 0", in_ready32);
        end
        instruction = 32'h00112623; in_tag = 8'd3;
        @(negedge clk);
        checks++;
        if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall_flags: got ready=%b valid=%b expected 0/1",
                     in_ready32, out_valid32);
        end
        checks++;
        if (tag32 !== 8'd1 || imm32 !== 32'hFFFFFFFF || type32 !== 3'd1) begin
            errors++;
            $display("FAIL bp_stall_hold: got tag=%h imm=%h type=%0d expected 01/ffffffff/1",
                     tag32, imm32, type32);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b1 || tag32 !== 8'd2 || imm32 !== 32'h80000000) begin
            errors++;
            $display("FAIL bp_second: got valid=%b tag=%h imm=%h expected 1/02/80000000",
                     out_valid32, tag32, imm32);
        end
        checks++;
        if (in_ready32 !== 1'b1) begin
            errors++; $display("FAIL bp_ready_reopen: got %b expected 1", in_ready32);
        end
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b1 || tag32 !== 8'd3 || imm32 !== 32'h0000000C) begin
            errors++;
            $display("FAIL bp_third: got valid=%b tag=%h imm=%h expected 1/03/0000000c",
                     out_valid32, tag32, imm32);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b0) begin
            errors++; $display("FAIL bp_drain: got %b expected 0", out_valid32);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; instruction = 32'hFFF00093; in_tag = 8'h11;
        @(negedge clk);
        in_tag = 8'h12;
        @(negedge clk);
        checks++;
        if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: got ready=%b valid=%b expected 0/1", in_ready32, out_valid32);
        end
        flush = 1'b1; in_tag = 8'h13;
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: got valid=%b ready=%b expected 0/1", out_valid32, in_ready32);
        end
        // Input offered while ready and flushing must be dropped too.
        out_ready = 1'b1; in_tag = 8'h14;
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b0) begin
            errors++; $display("FAIL flush_drop_ready: got valid=%b tag=%h expected 0", out_valid32, tag32);
        end
        flush = 1'b0; in_tag = 8'h15;
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b1 || tag32 !== 8'h15) begin
            errors++;
            $display("FAIL flush_recover: got valid=%b tag=%h expected 1/15", out_valid32, tag32);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b0) begin
            errors++; $display("FAIL flush_no_ghost: got valid=%b tag=%h expected 0", out_valid32, tag32);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; instruction = 32'h800000B7; in_tag = 8'h21;
        @(negedge clk);
        in_tag = 8'h22;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid32 !== 1'b1 || in_ready32 !== 1'b0) begin
            errors++;
            $display("FAIL arst_pre: got valid=%b ready=%b expected 1/0", out_valid32, in_ready32);
        end
        // Assert between edges and sample before the next rising edge.
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
            errors++;
            $display("FAIL arst_flags: got valid=%b ready=%b expected 0/1", out_valid32, in_ready32);
        end
        checks++;
        if (imm32 !== 32'h0 || imm64 !== 64'h0 || type32 !== 3'd0 || tag32 !== 8'h00) begin
            errors++;
            $display("FAIL arst_data: got imm=%h/%h type=%0d tag=%h expected zeros",
                     imm32, imm64, type32, tag32);
        end
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; instruction = 32'hFFF00093; in_tag = 8'h23;
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b1 || tag32 !== 8'h23 || imm32 !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL arst_first_out: got valid=%b tag=%h imm=%h expected 1/23/ffffffff",
                     out_valid32, tag32, imm32);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b0) begin
            errors++; $display("FAIL arst_no_stale: got valid=%b tag=%h expected 0", out_valid32, tag32);
        end
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        instruction = 32'h0;
        in_tag      = 8'h00;
        out_ready   = 1'b0;

        test_reset();
        test_decode_stream();
        test_backpressure();
        test_flush();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
